ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//   Instruction fetch stage directly upstream of the simulated instruction memory. Owns the PC,
//   issues one word-aligned read per instruction over a req/rsp port, buffers returned
//   {pc,inst} pairs in a small FIFO, and hands them to the decode stage via valid/ready.
//   Accepts redirects (branch/jump/trap) from execute; flushes buffered and in-flight fetches.
// PARAMETERS
//   XLEN        32            address/PC width
//   RESET_PC    32'h8000_0000 PC after reset
//   FIFO_DEPTH  2             fetch buffer entries (power of two, >=2)
// PORTS
//   clock           in   1     single clock, rising edge
//   reset           in   1     asynchronous, active-high
//   redirect_valid  in   1     load redirect_pc this cycle, flush everything
//   redirect_pc     in   XLEN  new PC; bits [1:0] ignored (treated as 0)
//   imem_req_valid  out  1     read request valid
//   imem_req_ready  in   1     memory accepts request
//   imem_req_addr   out  XLEN  word-aligned fetch address
//   imem_rsp_valid  in   1     read data valid (no ready; must be taken)
//   imem_rsp_inst   in   32    instruction word
//   out_valid       out  1     decode-side valid
//   out_ready       in   1     decode-side ready
//   out_pc          out  XLEN  PC of out_inst
//   out_inst        out  32    instruction
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=IDLE, FIFO empty; imem_req_valid=0, out_valid=0,
//     imem_req_addr=RESET_PC, out_pc/out_inst=0. IDLE->REQ unconditionally on first edge.
//   States: IDLE, REQ, WAIT, DISCARD. At most one request outstanding.
//   REQ: imem_req_valid=(count<FIFO_DEPTH) && !redirect_valid; addr=pc.
//     Handshake -> WAIT, req_pc<=pc.
//   WAIT: first imem_rsp_valid pushes {req_pc,imem_rsp_inst}, pc<=req_pc+4 (mod 2^XLEN),
//     ->REQ. Response earliest 1 cycle after request handshake; rsp_valid outside WAIT/DISCARD ignored.
//   DISCARD: next imem_rsp_valid is dropped, ->REQ.
//   Redirect (highest priority, any state): pc<=redirect_pc&~3; FIFO cleared (out_valid=0 next cycle,
//     pop ignored); next state: WAIT->DISCARD unless rsp_valid same cycle (dropped, ->REQ);
//     DISCARD stays DISCARD unless rsp_valid same cycle (->REQ); IDLE/REQ->REQ. A request is never
//     issued in a redirect cycle, so no new in-flight fetch is created by it.
//   Latency: redirect -> req at new PC next cycle (if no pending discard); rsp -> out_valid next cycle.
//   FIFO: out_* = head; stable while out_valid && !out_ready. Push and pop same cycle allowed
//     at any occupancy incl. full (count unchanged). Issue gated on count<FIFO_DEPTH guarantees
//     space at push time since decode can only pop. Pointers wrap mod FIFO_DEPTH.
//   Reset mid-operation: immediate return to reset values; late responses land in IDLE and are ignored.
// STRUCTURE
//   ifu_pkg: fetch_state_e {IDLE,REQ,WAIT,DISCARD}; fetch_bundle_t {logic [XLEN-1:0] pc;
//     logic [31:0] inst}; RESET_PC_DEFAULT.
//   Sub-module ifu_inst_fifo (#DEPTH, fetch_bundle_t): push/pop/flush, count, head, full/empty.
//   Top holds pc, req_pc, state FSM, handshake glue.
// TESTING
//   1 Reset then mem 1-cycle latency, out_ready=1 -> req addrs 8000_0000, _0004, _0008;
//     out_pc matches, out_inst = mem word.
//   2 out_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid=0 while full,
//     out_* unchanged; release -> in-order drain, fetch resumes at 8000_0008.
//   3 Redirect to 8000_0100 during WAIT, rsp 3 cycles later -> stale rsp dropped, next req
//     addr 8000_0100, no stale PC reaches decode.
//   4 Redirect coincident with rsp_valid in WAIT -> rsp dropped, req at redirect_pc next cycle.
//   5 Redirect to 8000_0103 -> req addr 8000_0100; PC FFFF_FFFC fetched -> next addr 0000_0000.
//   6 Assert reset while WAIT with 1 entry buffered -> out_valid=0, state IDLE, restart at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int IFU_XLEN = 32;
   localparam logic [IFU_XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DISCARD
   } fetch_state_e;

   typedef struct packed {
      logic [IFU_XLEN-1:0] pc;
      logic [31:0]         inst;
   } fetch_bundle_t;

endpackage

// File: rtl/ifu_inst_fifo.sv
// Small power-of-two FIFO of {pc,inst} bundles between fetch and decode.
module ifu_inst_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  fetch_bundle_t push_data,
   input  logic          pop,
   output fetch_bundle_t head,
   output logic          full,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   fetch_bundle_t   mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: storage is reset so the head reads as zero out of reset; cheap at this depth.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, issues one imem read at a time, buffers results for decode
// and handles redirects by flushing the buffer and discarding any in-flight response.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int              XLEN       = IFU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst
);

   if (XLEN != IFU_XLEN) begin : g_xlen_check
      $error("ifu_fetch: XLEN must match ifu_pkg::IFU_XLEN");
   end

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_push;
   fetch_bundle_t   push_data;
   fetch_bundle_t   head;

   // NOTE: request valid is combinational so a same-cycle redirect can suppress it.
   assign imem_req_valid = (state == REQ) && !fifo_full && !redirect_valid;
   assign imem_req_addr  = pc;

   assign fifo_push = (state == WAIT) && imem_rsp_valid && !redirect_valid;
   assign push_data = '{pc: req_pc, inst: imem_rsp_inst};

   assign out_valid = !fifo_empty;
   assign out_pc    = head.pc;
   assign out_inst  = head.inst;

   ifu_inst_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (out_ready),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc & ~XLEN'(3);
         // An outstanding fetch must be absorbed before new requests go out.
         case (state)
            WAIT, DISCARD: state <= imem_rsp_valid ? REQ : DISCARD;
            default:       state <= REQ;
         endcase
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (imem_req_valid && imem_req_ready) begin
                  req_pc <= pc;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  pc    <= req_pc + XLEN'(4);
                  state <= REQ;
               end
            end
            DISCARD: begin
               if (imem_rsp_valid) state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: behavioural imem responder plus decode-side monitor.
module tb_ifu_fetch;
   import ifu_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int redirect_cyc = 0;

   int          latency = 1;
   bit          rsp_pending = 1'b0;
   bit          rsp_stale = 1'b0;
   int          rsp_timer = 0;
   logic [31:0] rsp_addr = '0;

   fetch_bundle_t exp_q[$];
   logic [31:0]   req_log[$];
   int            req_cyc[$];
   logic [31:0]   out_log[$];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   ifu_fetch #(
      .XLEN       (32),
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_inst  (imem_rsp_inst),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst)
   );

   initial forever #5 clock = ~clock;
   initial forever begin @(posedge clock); cyc++; end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory responder and decode-side monitor; everything is sampled mid-cycle.
   initial forever begin
      @(negedge clock);
      #2;
      imem_rsp_valid = 1'b0;
      if (!reset && !redirect_valid && out_valid && out_ready) begin
         out_log.push_back(out_pc);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: pc=%h inst=%h, scoreboard empty", out_pc, out_inst);
         end else begin
            fetch_bundle_t e;
            e = exp_q.pop_front();
            if (out_pc !== e.pc || out_inst !== e.inst) begin
               n_err++;
               $display("FAIL out_bundle: got pc=%h inst=%h, want pc=%h inst=%h",
                        out_pc, out_inst, e.pc, e.inst);
            end
         end
      end
      if (rsp_pending) begin
         rsp_timer--;
         if (rsp_timer == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_inst  = inst_of(rsp_addr);
            rsp_pending    = 1'b0;
            if (!rsp_stale && !redirect_valid && !reset)
               exp_q.push_back('{pc: rsp_addr, inst: inst_of(rsp_addr)});
            rsp_stale = 1'b0;
         end
      end
      if (!reset && imem_req_valid && imem_req_ready) begin
         rsp_pending = 1'b1;
         rsp_timer   = latency;
         rsp_addr    = imem_req_addr;
         req_log.push_back(imem_req_addr);
         req_cyc.push_back(cyc);
      end
   end

   task automatic wait_req(input int n, input string tag);
      int b = 0;
      while (req_log.size() < n && b < 300) begin
         @(negedge clock); #3; b++;
      end
      if (req_log.size() < n) begin
         n_cmp++; n_err++;
         $display("FAIL %s_req_timeout: got %0d requests, want %0d", tag, req_log.size(), n);
      end
   endtask

   task automatic wait_out(input int n, input string tag);
      int b = 0;
      while (out_log.size() < n && b < 300) begin
         @(negedge clock); #3; b++;
      end
      if (out_log.size() < n) begin
         n_cmp++; n_err++;
         $display("FAIL %s_out_timeout: got %0d outputs, want %0d", tag, out_log.size(), n);
      end
   endtask

   task automatic cmp32(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   task automatic apply_reset();
      @(negedge clock); #1;
      reset = 1'b1;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      if (rsp_pending) rsp_stale = 1'b1;
      repeat (5) @(negedge clock);
      #1;
      exp_q.delete(); req_log.delete(); req_cyc.delete(); out_log.delete();
      reset = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      @(negedge clock); #1;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      if (rsp_pending) rsp_stale = 1'b1;
      exp_q.delete();
      redirect_cyc = cyc;
      @(negedge clock); #1;
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      latency = 1;
      #1 reset = 1'b1;
      #1;
      if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b, want 0", imem_req_valid); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, want 0", out_valid); end
      n_cmp++;
      cmp32("rst_req_addr", imem_req_addr, RST_PC);
      cmp32("rst_out_pc", out_pc, 32'h0);
      cmp32("rst_out_inst", out_inst, 32'h0);
      repeat (3) @(negedge clock);
      #1 reset = 1'b0;
      #2;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL idle_req_valid: got %b, want 0", imem_req_valid); end
      @(negedge clock); #3;
      n_cmp++;
      if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL req_after_idle: got %b, want 1", imem_req_valid); end
   endtask

   task automatic test_stream();
      apply_reset();
      latency = 1;
      out_ready = 1'b1;
      wait_req(3, "stream");
      wait_out(3, "stream");
      if (req_log.size() >= 3) begin
         cmp32("stream_req0", req_log[0], 32'h8000_0000);
         cmp32("stream_req1", req_log[1], 32'h8000_0004);
         cmp32("stream_req2", req_log[2], 32'h8000_0008);
      end
      if (out_log.size() >= 3) begin
         cmp32("stream_out0", out_log[0], 32'h8000_0000);
         cmp32("stream_out2", out_log[2], 32'h8000_0008);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      latency = 1;
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock); #3;
         if (i >= 7) begin
            n_cmp++;
            if (imem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
               n_err++;
               $display("FAIL bp_valids: req_valid=%b out_valid=%b, want 0/1", imem_req_valid, out_valid);
            end
            cmp32("bp_out_pc", out_pc, 32'h8000_0000);
            cmp32("bp_out_inst", out_inst, inst_of(32'h8000_0000));
         end
      end
      n_cmp++;
      if (exp_q.size() != 2 || req_log.size() != 2) begin
         n_err++;
         $display("FAIL bp_occupancy: buffered=%0d requests=%0d, want 2/2", exp_q.size(), req_log.size());
      end
      @(negedge clock); #1 out_ready = 1'b1;
      wait_out(3, "bp");
      wait_req(3, "bp");
      if (out_log.size() >= 2) begin
         cmp32("bp_drain0", out_log[0], 32'h8000_0000);
         cmp32("bp_drain1", out_log[1], 32'h8000_0004);
      end
      if (req_log.size() >= 3) cmp32("bp_resume", req_log[2], 32'h8000_0008);
   endtask

   task automatic test_redirect_wait();
      apply_reset();
      latency = 3;
      out_ready = 1'b1;
      wait_req(1, "rdw");
      do_redirect(32'h8000_0100);
      wait_req(2, "rdw");
      wait_out(2, "rdw");
      if (req_log.size() >= 2) begin
         cmp32("rdw_req_addr", req_log[1], 32'h8000_0100);
         cmp32("rdw_req_cycle", 32'(req_cyc[1]), 32'(redirect_cyc + 3));
      end
      if (out_log.size() >= 2) begin
         cmp32("rdw_out0", out_log[0], 32'h8000_0100);
         cmp32("rdw_out1", out_log[1], 32'h8000_0104);
      end
   endtask

   task automatic test_redirect_coincident();
      apply_reset();
      latency = 2;
      out_ready = 1'b1;
      wait_req(1, "rdc");
      @(negedge clock);
      do_redirect(32'h8000_0200);
      wait_req(2, "rdc");
      wait_out(1, "rdc");
      if (req_log.size() >= 2) begin
         cmp32("rdc_req_addr", req_log[1], 32'h8000_0200);
         cmp32("rdc_req_cycle", 32'(req_cyc[1]), 32'(redirect_cyc + 1));
      end
      if (out_log.size() >= 1) cmp32("rdc_out0", out_log[0], 32'h8000_0200);
   endtask

   task automatic test_align_wrap();
      apply_reset();
      latency = 1;
      out_ready = 1'b1;
      do_redirect(32'h8000_0103);
      wait_req(1, "align");
      wait_out(1, "align");
      if (req_log.size() >= 1) cmp32("align_req", req_log[0], 32'h8000_0100);
      if (out_log.size() >= 1) cmp32("align_out", out_log[0], 32'h8000_0100);
      apply_reset();
      out_ready = 1'b1;
      do_redirect(32'hFFFF_FFFC);
      wait_req(2, "wrap");
      wait_out(2, "wrap");
      if (req_log.size() >= 2) begin
         cmp32("wrap_req0", req_log[0], 32'hFFFF_FFFC);
         cmp32("wrap_req1", req_log[1], 32'h0000_0000);
      end
      if (out_log.size() >= 2) cmp32("wrap_out1", out_log[1], 32'h0000_0000);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      latency = 3;
      out_ready = 1'b0;
      wait_req(2, "rmid");
      n_cmp++;
      if (exp_q.size() != 1) begin
         n_err++;
         $display("FAIL rmid_buffered: got %0d entries, want 1", exp_q.size());
      end
      @(negedge clock); #1;
      reset = 1'b1;
      if (rsp_pending) rsp_stale = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_valids: out_valid=%b req_valid=%b, want 0/0", out_valid, imem_req_valid);
      end
      cmp32("rmid_addr", imem_req_addr, RST_PC);
      exp_q.delete(); req_log.delete(); req_cyc.delete(); out_log.delete();
      @(negedge clock);
      @(negedge clock); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      wait_req(1, "rmid");
      wait_out(1, "rmid");
      if (req_log.size() >= 1) cmp32("rmid_restart_req", req_log[0], RST_PC);
      if (out_log.size() >= 1) cmp32("rmid_restart_out", out_log[0], RST_PC);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_coincident();
      test_align_wrap();
      test_reset_mid();
      repeat (3) @(negedge clock);
      n_cmp++;
      if (exp_q.size() > 2) begin
         n_err++;
         $display("FAIL final_scoreboard: %0d entries never delivered", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
